run_detect_moore: RTL and testbench
===================================

RUN_DETECT_MOORE -- requirements
Module: run_detect_moore

Interface
REQ-001 SHALL have parameter RUN_LEN, default 2, the number of consecutive matching samples required for a hit (legal range 1..255).
REQ-002 SHALL have parameter MATCH_VAL, default 1'b1, the sample value that counts as a match.
REQ-003 SHALL have parameter MC_W, default 8, the width of the hit counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, sample-valid qualifier.
REQ-007 SHALL have port in, input, 1, the serial sample.
REQ-008 SHALL have port mode, input, 2, output mode: 00 level, 01 pulse, 10 periodic, 11 treated as level.
REQ-009 SHALL have port out, output, 1, Moore detect output.
REQ-010 SHALL have port run_cnt, output, RC_W = $clog2(RUN_LEN+1), the current consecutive-match count.
REQ-011 SHALL have port hit_cnt, output, MC_W, the saturating count of hits since reset.

Function
REQ-012 SHALL implement a Moore FSM with states S_IDLE, S_RUN, S_HIT and S_HOLD; out, run_cnt and hit_cnt SHALL depend only on registered state.
REQ-013 SHALL update state only on posedge clk with rst=0 and en=1; with en=0 all state, counters and out SHALL hold.
REQ-014 Mismatch (in != MATCH_VAL) from any state -> S_IDLE with run_cnt=0.
REQ-015 Match from S_IDLE or S_RUN -> run_cnt+1; if the result equals RUN_LEN -> S_HIT, else -> S_RUN.
REQ-016 Match from S_HIT in periodic mode -> run_cnt=1 and S_RUN (S_HIT if RUN_LEN=1); in level or pulse mode -> S_HOLD with run_cnt held at RUN_LEN.
REQ-017 Match from S_HOLD -> S_HOLD; in periodic mode S_HOLD SHALL be treated as S_HIT for the next transition.
REQ-018 out: level mode = (S_HIT or S_HOLD); pulse mode = S_HIT; periodic mode = S_HIT.
REQ-019 mode SHALL be decoded combinationally on out and sampled at each transition; a mode change takes effect on the same cycle for out and on the next edge for transitions.
REQ-020 Latency: out SHALL assert in the cycle following the edge that samples the RUN_LEN-th consecutive match.
REQ-021 hit_cnt SHALL increment by 1 on every entry into S_HIT and saturate at 2^MC_W-1 without wrapping.
REQ-022 run_cnt SHALL never exceed RUN_LEN.
REQ-023 Unreachable state encodings SHALL recover to S_IDLE on the next enabled edge.

Reset
REQ-024 rst=1 at posedge clk SHALL force S_IDLE, run_cnt=0, hit_cnt=0 and out=0, overriding en, in and mode, including mid-run.
REQ-025 The first enabled sample after reset release SHALL be evaluated from S_IDLE.

Structure
REQ-026 State encodings (S_IDLE=2'b00, S_RUN=2'b01, S_HIT=2'b10, S_HOLD=2'b11) and mode constants SHALL live in package run_detect_pkg.
REQ-027 hit_cnt SHALL be implemented by sub-module sat_counter (parameter W; ports clk, rst, inc, q).
REQ-028 The next-state logic SHALL be a combinational block separate from the state register; the default branch SHALL give S_IDLE.

Verification
REQ-029 RUN_LEN=2, level mode, in=0,1,1,1,0 -> out=0,0,0,1,1 then 0 after the 0; hit_cnt=1.
REQ-030 RUN_LEN=3, pulse mode, six consecutive 1s -> out high for exactly one cycle (after the 3rd 1); hit_cnt=1.
REQ-031 RUN_LEN=3, periodic mode, six consecutive 1s -> out pulses after the 3rd and 6th samples; hit_cnt=2; run_cnt sequence 1,2,3,1,2,3.
REQ-032 RUN_LEN=2, 1,1 with en=0 inserted between them for 4 cycles -> still a hit; out holds its value while en=0.
REQ-033 rst asserted while in S_HOLD -> next cycle out=0, run_cnt=0, hit_cnt=0; MC_W=2 with 5 hits -> hit_cnt saturates at 3.
REQ-034 RUN_LEN=1, MATCH_VAL=0, in=0,0,1 -> out=1,1,0 (level mode), with 1-cycle latency.

Source files
------------

// File: rtl/run_detect_pkg.sv
// Shared constants and decode helpers for the serial run detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package run_detect_pkg;

   // FSM state encodings
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_HIT  = 2'b10;
   localparam logic [1:0] S_HOLD = 2'b11;

   // Output mode encodings; 2'b11 is an alias of level mode
   localparam logic [1:0] MODE_LEVEL     = 2'b00;
   localparam logic [1:0] MODE_PULSE     = 2'b01;
   localparam logic [1:0] MODE_PERIODIC  = 2'b10;
   localparam logic [1:0] MODE_LEVEL_ALT = 2'b11;

   // Periodic mode restarts the run after each hit instead of holding
   function automatic logic mode_is_periodic(input logic [1:0] mode);
      logic p;
      p = (mode == MODE_PERIODIC);
      return p;
   endfunction

   // Moore output decode: level mode stays high through S_HOLD, the
   // other modes only flag the single S_HIT cycle.
   function automatic logic out_decode(input logic [1:0] state,
                                       input logic [1:0] mode);
      logic o;
      case (mode)
         MODE_PULSE, MODE_PERIODIC: o = (state == S_HIT);
         default:                   o = (state == S_HIT) || (state == S_HOLD);
      endcase
      return o;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
// Latency: q updates on the clock edge that samples inc.
// Backpressure: none; inc is ignored once q is saturated.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   // Count up on inc, never wrap past the all-ones value
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/run_detect_moore.sv
// Moore detector for RUN_LEN consecutive MATCH_VAL samples with level/pulse/periodic output.
// Latency: out rises the cycle after the edge sampling the RUN_LEN-th match.
// Backpressure: none; en=0 freezes state, counters and out.
module run_detect_moore
   import run_detect_pkg::*;
#(
   parameter int   RUN_LEN   = 2,
   parameter logic MATCH_VAL = 1'b1,
   parameter int   MC_W      = 8,
   localparam int  RC_W      = $clog2(RUN_LEN + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            in,
   input  logic [1:0]      mode,
   output logic            out,
   output logic [RC_W-1:0] run_cnt,
   output logic [MC_W-1:0] hit_cnt
);

   localparam logic [RC_W-1:0] RUN_FULL = RC_W'(RUN_LEN);
   localparam logic [RC_W-1:0] RUN_ONE  = RC_W'(1);
   // Count value at which one more match completes the run
   localparam logic [RC_W-1:0] RUN_LAST = RC_W'(RUN_LEN - 1);

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [RC_W-1:0] run_nxt;
   logic [RC_W-1:0] run_base;
   logic            match;
   logic            periodic;
   logic            hit_entry;

   assign match    = (in == MATCH_VAL);
   assign periodic = mode_is_periodic(mode);

   // S_IDLE always counts from zero, so a stray count can never leak in
   assign run_base = (state == S_IDLE) ? '0 : run_cnt;

   // Next-state and next-count decode; any mismatch falls back to idle
   always_comb begin
      state_nxt = S_IDLE;
      run_nxt   = '0;
      if (match) begin
         case (state)
            S_IDLE, S_RUN: begin
               // >= keeps run_cnt clamped at RUN_LEN even from a bad count
               if (run_base >= RUN_LAST) begin
                  run_nxt   = RUN_FULL;
                  state_nxt = S_HIT;
               end else begin
                  run_nxt   = run_base + RUN_ONE;
                  state_nxt = S_RUN;
               end
            end
            S_HIT, S_HOLD: begin
               // Periodic mode treats a held hit as fresh and restarts the run;
               // with RUN_LEN=1 the restart is itself a complete run.
               if (periodic) begin
                  run_nxt   = RUN_ONE;
                  state_nxt = (RUN_LEN == 1) ? S_HIT : S_RUN;
               end else begin
                  run_nxt   = RUN_FULL;
                  state_nxt = S_HOLD;
               end
            end
            default: begin
               run_nxt   = '0;
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State and run-count register; reset wins, en=0 holds everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         run_cnt <= '0;
      end else if (en) begin
         state   <= state_nxt;
         run_cnt <= run_nxt;
      end
   end

   // Every enabled transition landing in S_HIT is a new hit, including
   // back-to-back hits in periodic mode with RUN_LEN=1.
   assign hit_entry = en && (state_nxt == S_HIT);

   sat_counter #(
      .W (MC_W)
   ) u_hit_cnt (
      .clk (clk),
      .rst (rst),
      .inc (hit_entry),
      .q   (hit_cnt)
   );

   // Moore output: registered state, mode applied combinationally
   assign out = out_decode(state, mode);

endmodule

// File: tb/tb_run_detect_moore.sv
// Self-checking bench: directed vectors plus randomized streams vs a streak-length model.
// Latency: checks sample outputs on the falling edge after each rising edge.
// Backpressure: none; en is randomized to exercise hold cycles.
module tb_run_detect_moore;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       din;
   logic [1:0] mode;

   always #5 clk = ~clk;

   // Four instances share stimulus but differ in parameters
   logic       out_d2, out_d3, out_d1, out_ds;
   logic [1:0] rc_d2, rc_d3, rc_ds;
   logic [0:0] rc_d1;
   logic [7:0] hc_d2, hc_d3, hc_d1;
   logic [1:0] hc_ds;

   run_detect_moore #(.RUN_LEN(2), .MATCH_VAL(1'b1), .MC_W(8)) u_d2 (
      .clk(clk), .rst(rst), .en(en), .in(din), .mode(mode),
      .out(out_d2), .run_cnt(rc_d2), .hit_cnt(hc_d2));
   run_detect_moore #(.RUN_LEN(3), .MATCH_VAL(1'b1), .MC_W(8)) u_d3 (
      .clk(clk), .rst(rst), .en(en), .in(din), .mode(mode),
      .out(out_d3), .run_cnt(rc_d3), .hit_cnt(hc_d3));
   run_detect_moore #(.RUN_LEN(1), .MATCH_VAL(1'b0), .MC_W(8)) u_d1 (
      .clk(clk), .rst(rst), .en(en), .in(din), .mode(mode),
      .out(out_d1), .run_cnt(rc_d1), .hit_cnt(hc_d1));
   run_detect_moore #(.RUN_LEN(2), .MATCH_VAL(1'b1), .MC_W(2)) u_ds (
      .clk(clk), .rst(rst), .en(en), .in(din), .mode(mode),
      .out(out_ds), .run_cnt(rc_ds), .hit_cnt(hc_ds));

   int act_out [4];
   int act_run [4];
   int act_hit [4];
   assign act_out[0] = int'(out_d2);
   assign act_out[1] = int'(out_d3);
   assign act_out[2] = int'(out_d1);
   assign act_out[3] = int'(out_ds);
   assign act_run[0] = int'(rc_d2);
   assign act_run[1] = int'(rc_d3);
   assign act_run[2] = int'(rc_d1);
   assign act_run[3] = int'(rc_ds);
   assign act_hit[0] = int'(hc_d2);
   assign act_hit[1] = int'(hc_d3);
   assign act_hit[2] = int'(hc_d1);
   assign act_hit[3] = int'(hc_ds);

   // Reference model: length of the current streak of enabled matches,
   // plus the number of completed runs, saturated per instance.
   int   rl   [4] = '{2, 3, 1, 2};
   logic mv   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   int   hmax [4] = '{255, 255, 255, 3};
   int   streak [4];
   int   hits   [4];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic e, input logic i,
                             input logic [1:0] m);
      for (int k = 0; k < 4; k++) begin
         if (r) begin
            streak[k] = 0;
            hits[k]   = 0;
         end else if (e) begin
            if (i != mv[k]) begin
               streak[k] = 0;
            end else begin
               streak[k]++;
               if ((m == 2'b10) ? (streak[k] % rl[k] == 0) : (streak[k] == rl[k]))
                  if (hits[k] < hmax[k]) hits[k]++;
            end
         end
      end
   endtask

   function automatic int exp_out(input int k, input logic [1:0] m);
      if (m == 2'b10) return (streak[k] > 0 && streak[k] % rl[k] == 0) ? 1 : 0;
      if (m == 2'b01) return (streak[k] == rl[k]) ? 1 : 0;
      return (streak[k] >= rl[k]) ? 1 : 0;
   endfunction

   function automatic int exp_run(input int k, input logic [1:0] m);
      if (streak[k] == 0) return 0;
      if (m == 2'b10) return ((streak[k] - 1) % rl[k]) + 1;
      return (streak[k] < rl[k]) ? streak[k] : rl[k];
   endfunction

   // One clock: drive at the falling edge, let the rising edge sample,
   // return at the next falling edge with outputs settled.
   task automatic cyc(input logic r, input logic e, input logic i, input logic [1:0] m);
      rst  = r;
      en   = e;
      din  = i;
      mode = m;
      @(posedge clk);
      model_step(r, e, i, m);
      @(negedge clk);
   endtask

   typedef struct {
      logic       rst;
      logic       en;
      logic       din;
      logic [1:0] mode;
      int         e_out;
      int         e_run;
      int         e_hit;
   } vec_t;

   vec_t tbl [22];

   int po [6];
   int pr [6];
   int qo [6];
   int qr [6];
   int d1o [3];
   int d1r [3];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      din  = 1'b0;
      mode = 2'b00;

      // Directed vectors for the RUN_LEN=2 instance: {rst,en,in,mode} -> {out,run_cnt,hit_cnt}
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'b00, 0, 1, 0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'b00, 1, 2, 1};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'b00, 1, 2, 1};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 1};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'b00, 0, 1, 1};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'b00, 0, 1, 1};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 0, 1, 1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'b00, 0, 1, 1};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 0, 1, 1};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 2'b00, 1, 2, 2};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 2'b00, 1, 2, 2};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 2'b00, 1, 2, 2};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 2'b00, 0, 0, 0};
      tbl[15] = '{1'b0, 1'b1, 1'b1, 2'b00, 0, 1, 0};
      tbl[16] = '{1'b0, 1'b1, 1'b1, 2'b00, 1, 2, 1};
      tbl[17] = '{1'b0, 1'b1, 1'b1, 2'b01, 0, 2, 1};
      tbl[18] = '{1'b0, 1'b1, 1'b1, 2'b10, 0, 1, 1};
      tbl[19] = '{1'b0, 1'b1, 1'b1, 2'b10, 1, 2, 2};
      tbl[20] = '{1'b0, 1'b1, 1'b1, 2'b11, 1, 2, 2};
      tbl[21] = '{1'b0, 1'b1, 1'b0, 2'b11, 0, 0, 2};

      po = '{0, 0, 1, 0, 0, 0};
      pr = '{1, 2, 3, 3, 3, 3};
      qo = '{0, 0, 1, 0, 0, 1};
      qr = '{1, 2, 3, 1, 2, 3};
      d1o = '{1, 1, 0};
      d1r = '{1, 1, 0};

      @(negedge clk);

      for (int t = 0; t < 22; t++) begin
         cyc(tbl[t].rst, tbl[t].en, tbl[t].din, tbl[t].mode);
         chk($sformatf("vec%0d_out", t), act_out[0], tbl[t].e_out);
         chk($sformatf("vec%0d_run", t), act_run[0], tbl[t].e_run);
         chk($sformatf("vec%0d_hit", t), act_hit[0], tbl[t].e_hit);
      end

      // Mode change reaches out in the same cycle, without a clock edge
      cyc(1'b1, 1'b0, 1'b0, 2'b00);
      cyc(1'b0, 1'b1, 1'b1, 2'b00);
      cyc(1'b0, 1'b1, 1'b1, 2'b00);
      cyc(1'b0, 1'b1, 1'b1, 2'b00);
      chk("hold_level_out", act_out[0], 1);
      mode = 2'b01;
      #1;
      chk("hold_pulse_out_comb", act_out[0], 0);
      mode = 2'b00;
      #1;
      chk("hold_level_out_comb", act_out[0], 1);

      // RUN_LEN=3 pulse mode, six consecutive matches
      cyc(1'b1, 1'b0, 1'b0, 2'b01);
      for (int s = 0; s < 6; s++) begin
         cyc(1'b0, 1'b1, 1'b1, 2'b01);
         chk($sformatf("pulse3_out%0d", s), act_out[1], po[s]);
         chk($sformatf("pulse3_run%0d", s), act_run[1], pr[s]);
      end
      chk("pulse3_hit", act_hit[1], 1);

      // RUN_LEN=3 periodic mode, six consecutive matches
      cyc(1'b1, 1'b0, 1'b0, 2'b10);
      for (int s = 0; s < 6; s++) begin
         cyc(1'b0, 1'b1, 1'b1, 2'b10);
         chk($sformatf("per3_out%0d", s), act_out[1], qo[s]);
         chk($sformatf("per3_run%0d", s), act_run[1], qr[s]);
      end
      chk("per3_hit", act_hit[1], 2);

      // RUN_LEN=1, MATCH_VAL=0, level: in=0,0,1
      cyc(1'b1, 1'b0, 1'b0, 2'b00);
      chk("d1_reset_out", act_out[2], 0);
      for (int s = 0; s < 3; s++) begin
         cyc(1'b0, 1'b1, (s == 2) ? 1'b1 : 1'b0, 2'b00);
         chk($sformatf("d1_out%0d", s), act_out[2], d1o[s]);
         chk($sformatf("d1_run%0d", s), act_run[2], d1r[s]);
      end
      chk("d1_hit", act_hit[2], 1);

      // MC_W=2 counter saturates at 3 after five periodic hits
      cyc(1'b1, 1'b0, 1'b0, 2'b10);
      for (int s = 1; s <= 10; s++) begin
         cyc(1'b0, 1'b1, 1'b1, 2'b10);
         if (s % 2 == 0)
            chk($sformatf("sat_hit%0d", s / 2), act_hit[3], (s / 2 < 3) ? s / 2 : 3);
      end

      // Randomized segments, one fixed mode per segment after a reset
      for (int seg = 0; seg < 10; seg++) begin
         logic [1:0] m;
         int         bias;
         m    = 2'($urandom_range(0, 3));
         bias = (seg % 2 == 1) ? 85 : 50;
         cyc(1'b1, 1'b1, 1'b1, m);
         for (int c = 0; c < 150; c++) begin
            logic r, e, i;
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 99) < 75);
            i = ($urandom_range(0, 99) < bias);
            cyc(r, e, i, m);
            for (int k = 0; k < 4; k++) begin
               chk($sformatf("rnd_s%0d_c%0d_i%0d_out", seg, c, k), act_out[k], exp_out(k, m));
               chk($sformatf("rnd_s%0d_c%0d_i%0d_run", seg, c, k), act_run[k], exp_run(k, m));
               chk($sformatf("rnd_s%0d_c%0d_i%0d_hit", seg, c, k), act_hit[k], hits[k]);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
